// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Types and constants shared by the conv, pool and FC stages of the CNN path.
//   DATA_W  : pixel width (signed two's complement)
//   pixel_t : signed pixel type
//   cnt_w() : width of a counter/address that indexes n items (minimum 1 bit)
// ---------------------------------------------------------------------------
package cnn_pkg;

  localparam int DATA_W = 13;

  typedef logic signed [DATA_W-1:0] pixel_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// ---------------------------------------------------------------------------
// pool_line_buffer
// One-row pixel store for the 2x2 window former. It holds the even row so
// that the odd row can be paired with it.
//   clk       : write clock
//   we        : write enable
//   waddr     : write column
//   wdata     : pixel to store
//   raddr_a/b : read columns (combinational read)
//   rdata_a/b : stored pixels at raddr_a/raddr_b
// ---------------------------------------------------------------------------
module pool_line_buffer
  import cnn_pkg::*;
#(
  parameter int IMG_W = 26,
  parameter int AW    = cnt_w(IMG_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  pixel_t mem [IMG_W];

  // NOTE: storage arrays carry no reset; their contents are always written
  // before being read, and leaving the reset off keeps them in distributed RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/pool_window_gather.sv
// ---------------------------------------------------------------------------
// pool_window_gather
// Turns a raster-scan pixel stream into non-overlapping 2x2 windows for the
// 4-input max-pool stage. No backpressure: the consumer always accepts.
//   clk, rst_n            : clock, async active-low reset
//   clear                 : synchronous frame restart (drops a same-cycle pixel)
//   in_valid, in_data     : pixel stream, row-major
//   win_tl/tr/bl/br       : window pixels (2r,2c) (2r,2c+1) (2r+1,2c) (2r+1,2c+1)
//   win_valid             : one-cycle pulse, window outputs valid
//   frame_done            : pulses with the last window of a frame
// ---------------------------------------------------------------------------
module pool_window_gather
  import cnn_pkg::*;
#(
  parameter int IMG_W = 26,
  parameter int IMG_H = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] win_tl,
  output logic [DATA_W-1:0] win_tr,
  output logic [DATA_W-1:0] win_bl,
  output logic [DATA_W-1:0] win_br,
  output logic              win_valid,
  output logic              frame_done
);

  localparam int AW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);

  localparam logic [AW-1:0] COL_LAST     = AW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
  // Bottom-right pixel of the last complete window; odd trailing
  // rows/columns are consumed but never close a window.
  localparam logic [AW-1:0] LAST_WIN_COL = AW'(2 * (IMG_W / 2) - 1);
  localparam logic [RW-1:0] LAST_WIN_ROW = RW'(2 * (IMG_H / 2) - 1);

  logic [AW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  pixel_t        prev_q;
  pixel_t        tl_q, tr_q, bl_q, br_q;
  logic          win_valid_q, frame_done_q;

  logic          accept, complete, last_win;
  logic [AW-1:0] raddr_a;
  logic [DATA_W-1:0] rdata_a, rdata_b;

  // Windows close on an odd column, so col-1 is col with bit 0 cleared;
  // this never underflows even when col is 0.
  assign raddr_a = col_q & ~AW'(1);

  pool_line_buffer #(.IMG_W(IMG_W), .AW(AW)) u_line_buf (
    .clk     (clk),
    .we      (accept & ~row_q[0]),
    .waddr   (col_q),
    .wdata   (in_data),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a),
    .raddr_b (col_q),
    .rdata_b (rdata_b)
  );

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    accept   = in_valid & ~clear;
    complete = accept & row_q[0] & col_q[0];
    last_win = complete & (col_q == LAST_WIN_COL) & (row_q == LAST_WIN_ROW);
    col_d    = col_q;
    row_d    = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + AW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      prev_q       <= '0;
      tl_q         <= '0;
      tr_q         <= '0;
      bl_q         <= '0;
      br_q         <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= complete;
      frame_done_q <= last_win;
      if (accept) prev_q <= in_data;
      if (complete) begin
        tl_q <= rdata_a;
        tr_q <= rdata_b;
        bl_q <= prev_q;
        br_q <= in_data;
      end
    end
  end

  assign win_tl     = tl_q;
  assign win_tr     = tr_q;
  assign win_bl     = bl_q;
  assign win_br     = br_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool_window_gather.sv
// ---------------------------------------------------------------------------
// tb_pool_window_gather
// Directed bench for pool_window_gather: three instances (4x4, 2x2, 5x3)
// share one input stream; each step checks only the instance under test and
// opens with a clear so the instances start from (0,0).
// ---------------------------------------------------------------------------
module tb_pool_window_gather;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [12:0] in_data = '0;

  logic [12:0] a_tl, a_tr, a_bl, a_br;
  logic        a_v, a_d;
  logic [12:0] b_tl, b_tr, b_bl, b_br;
  logic        b_v, b_d;
  logic [12:0] c_tl, c_tr, c_bl, c_br;
  logic        c_v, c_d;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pool_window_gather #(.IMG_W(4), .IMG_H(4)) u44 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .win_tl(a_tl), .win_tr(a_tr), .win_bl(a_bl), .win_br(a_br),
    .win_valid(a_v), .frame_done(a_d));

  pool_window_gather #(.IMG_W(2), .IMG_H(2)) u22 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .win_tl(b_tl), .win_tr(b_tr), .win_bl(b_bl), .win_br(b_br),
    .win_valid(b_v), .frame_done(b_d));

  pool_window_gather #(.IMG_W(5), .IMG_H(3)) u53 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .win_tl(c_tl), .win_tr(c_tr), .win_bl(c_bl), .win_br(c_br),
    .win_valid(c_v), .frame_done(c_d));

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] px(input int v);
    return v[12:0];
  endfunction

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic [12:0] d, input logic clr);
    in_valid = v;
    in_data  = d;
    clear    = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic do_clear();
    step(1'b0, '0, 1'b1);
  endtask

  // 4x4 frame: pixels base..base+n-1 with `gap` bubbles after each.
  // Windows close on pixels 5/7/13/15 with top-left offsets 0/2/8/10.
  task automatic frame44(input int base, input int gap, input int n);
    int off;
    logic exp_v;
    logic [12:0] last_tl;
    last_tl = a_tl;
    for (int i = 0; i < n; i++) begin
      step(1'b1, px(base + i), 1'b0);
      exp_v = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      check("a_valid", {12'd0, a_v}, {12'd0, exp_v});
      check("a_done", {12'd0, a_d}, {12'd0, (i == 15)});
      if (exp_v) begin
        off = (i == 5) ? 0 : (i == 7) ? 2 : (i == 13) ? 8 : 10;
        check("a_tl", a_tl, px(base + off));
        check("a_tr", a_tr, px(base + off + 1));
        check("a_bl", a_bl, px(base + off + 4));
        check("a_br", a_br, px(base + off + 5));
        last_tl = px(base + off);
      end
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 13'h1555, 1'b0);
        check("a_bubble_valid", {12'd0, a_v}, 13'd0);
        check("a_hold_tl", a_tl, last_tl);
      end
    end
  endtask

  initial begin
    logic [12:0] sv [4];
    logic        exp_v;

    // Reset state.
    #2;
    check("rst_valid", {12'd0, a_v}, 13'd0);
    check("rst_done", {12'd0, a_d}, 13'd0);
    check("rst_tl", a_tl, 13'd0);
    check("rst_br", a_br, 13'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic frame order.
    do_clear();
    frame44(0, 0, 16);

    // Sign preservation on the 2x2 instance.
    do_clear();
    sv[0] = 13'h1000; sv[1] = 13'h0FFF; sv[2] = 13'h1FFF; sv[3] = 13'h0000;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, sv[i], 1'b0);
      check("b_valid", {12'd0, b_v}, {12'd0, (i == 3)});
    end
    check("b_tl", b_tl, 13'h1000);
    check("b_tr", b_tr, 13'h0FFF);
    check("b_bl", b_bl, 13'h1FFF);
    check("b_br", b_br, 13'h0000);
    check("b_done", {12'd0, b_d}, 13'd1);

    // Bubbles: in_valid 1,0,0,1,...
    do_clear();
    frame44(0, 2, 16);

    // Back-to-back frames, no idle cycle.
    do_clear();
    frame44(0, 0, 16);
    frame44(16, 0, 16);

    // Odd dimensions on the 5x3 instance, then a partial frame to show the
    // counters returned to (0,0).
    do_clear();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < ((f == 0) ? 15 : 9); i++) begin
        step(1'b1, px(i), 1'b0);
        exp_v = (i == 6) || (i == 8);
        check("c_valid", {12'd0, c_v}, {12'd0, exp_v});
        check("c_done", {12'd0, c_d}, {12'd0, (i == 8)});
        if (i == 6) begin
          check("c_w0_tl", c_tl, 13'd0);
          check("c_w0_tr", c_tr, 13'd1);
          check("c_w0_bl", c_bl, 13'd5);
          check("c_w0_br", c_br, 13'd6);
        end
        if (i == 8) begin
          check("c_w1_tl", c_tl, 13'd2);
          check("c_w1_tr", c_tr, 13'd3);
          check("c_w1_bl", c_bl, 13'd7);
          check("c_w1_br", c_br, 13'd8);
        end
      end
    end

    // Abort by asynchronous reset after pixel 6, then a full frame.
    do_clear();
    frame44(100, 0, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_rst_valid", {12'd0, a_v}, 13'd0);
    check("abort_rst_tl", a_tl, 13'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame44(0, 0, 16);

    // Abort by clear after pixel 6; the pixel presented with clear is dropped.
    frame44(200, 0, 7);
    step(1'b1, 13'd99, 1'b1);
    check("abort_clr_valid", {12'd0, a_v}, 13'd0);
    check("abort_clr_done", {12'd0, a_d}, 13'd0);
    frame44(0, 0, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
